pipe_hazard_ctrl: RTL

- Hazard and stall controller for the 5-stage MIPS pipeline.
- Decodes the instructions held in the D, E and M pipeline registers and decides when the pipeline must stall on a data hazard.
- Tracks the multi-cycle HI/LO multiply/divide unit with an internal busy counter.
- Drives PC/D-register hold enables and the E-register clear that inserts a bubble.

---
 rtl/pipe_hazard_ctrl.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/hold/bubble controller for the 5-stage MIPS pipeline
//
// Purpose:
//   Decodes the instructions in the D, E and M pipeline registers. Holds PC and D
//   and bubbles E when an operand in D is not ready in time for its Tuse, or when
//   D needs the HI/LO unit while a multiply/divide is in flight.
//
// Ports:
//   clk      in   1   clock, rising edge
//   rst      in   1   synchronous, active-high reset (clears the busy counter)
//   instrD   in  32   instruction in D stage
//   instrE   in  32   instruction in E stage
//   instrM   in  32   instruction in M stage
//   stall    out  1   hazard detected this cycle (combinational)
//   pc_en    out  1   PC write enable (~stall)
//   d_en     out  1   D register enable (~stall)
//   e_clr    out  1   E register clear, inserts a nop (stall)
//   md_busy  out  1   mult/div unit occupied

module pipe_hazard_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CNT_W       = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instrD,
   input  logic [31:0] instrE,
   input  logic [31:0] instrM,
   output logic        stall,
   output logic        pc_en,
   output logic        d_en,
   output logic        e_clr,
   output logic        md_busy
);

   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] OP_ORI     = 6'b001101;
   localparam logic [5:0] OP_LW      = 6'b100011;
   localparam logic [5:0] OP_SW      = 6'b101011;
   localparam logic [5:0] OP_BEQ     = 6'b000100;
   localparam logic [5:0] OP_LUI     = 6'b001111;
   localparam logic [5:0] OP_JAL     = 6'b000011;

   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUBU  = 6'b100011;
   localparam logic [5:0] FN_JR    = 6'b001000;
   localparam logic [5:0] FN_MULT  = 6'b011000;
   localparam logic [5:0] FN_MULTU = 6'b011001;
   localparam logic [5:0] FN_DIV   = 6'b011010;
   localparam logic [5:0] FN_DIVU  = 6'b011011;
   localparam logic [5:0] FN_MFHI  = 6'b010000;
   localparam logic [5:0] FN_MFLO  = 6'b010010;
   localparam logic [5:0] FN_MTHI  = 6'b010001;
   localparam logic [5:0] FN_MTLO  = 6'b010011;

   // Source usage of one instruction: valid flag and Tuse for rs and rt.
   typedef struct packed {
      logic       rs_v;
      logic [1:0] rs_t;
      logic       rt_v;
      logic [1:0] rt_t;
   } src_t;

   function automatic src_t src_of(input logic [31:0] ins);
      src_t s;
      s = '0;
      case (ins[31:26])
         OP_SPECIAL: begin
            case (ins[5:0])
               FN_ADDU, FN_SUBU, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                  s.rs_v = 1'b1; s.rs_t = 2'd1;
                  s.rt_v = 1'b1; s.rt_t = 2'd1;
               end
               FN_JR: begin
                  s.rs_v = 1'b1; s.rs_t = 2'd0;
               end
               FN_MTHI, FN_MTLO: begin
                  s.rs_v = 1'b1; s.rs_t = 2'd1;
               end
               default: s = '0;
            endcase
         end
         OP_ORI, OP_LW: begin
            s.rs_v = 1'b1; s.rs_t = 2'd1;
         end
         OP_SW: begin
            s.rs_v = 1'b1; s.rs_t = 2'd1;
            s.rt_v = 1'b1; s.rt_t = 2'd2;
         end
         OP_BEQ: begin
            s.rs_v = 1'b1; s.rs_t = 2'd0;
            s.rt_v = 1'b1; s.rt_t = 2'd0;
         end
         default: s = '0;
      endcase
      return s;
   endfunction

   // Destination register; 0 means "writes nothing", which also covers $0 immunity.
   function automatic logic [4:0] dst_of(input logic [31:0] ins);
      logic [4:0] d;
      d = 5'd0;
      case (ins[31:26])
         OP_SPECIAL: begin
            case (ins[5:0])
               FN_ADDU, FN_SUBU, FN_MFHI, FN_MFLO: d = ins[15:11];
               default:                            d = 5'd0;
            endcase
         end
         OP_ORI, OP_LUI, OP_LW: d = ins[20:16];
         OP_JAL:                d = 5'd31;
         default:               d = 5'd0;
      endcase
      return d;
   endfunction

   // Cycles until the result exists, measured from the E stage.
   function automatic logic [1:0] tnew_e_of(input logic [31:0] ins);
      logic [1:0] t;
      t = 2'd0;
      case (ins[31:26])
         OP_LW:          t = 2'd2;
         OP_ORI, OP_LUI: t = 2'd1;
         OP_SPECIAL: begin
            case (ins[5:0])
               FN_ADDU, FN_SUBU, FN_MFHI, FN_MFLO: t = 2'd1;
               default:                            t = 2'd0;
            endcase
         end
         default: t = 2'd0;
      endcase
      return t;
   endfunction

   // From the M stage only a load still has a result outstanding.
   function automatic logic [1:0] tnew_m_of(input logic [31:0] ins);
      return (ins[31:26] == OP_LW) ? 2'd1 : 2'd0;
   endfunction

   function automatic logic is_muldiv(input logic [31:0] ins);
      return (ins[31:26] == OP_SPECIAL) &&
             (ins[5:0] == FN_MULT || ins[5:0] == FN_MULTU ||
              ins[5:0] == FN_DIV  || ins[5:0] == FN_DIVU);
   endfunction

   function automatic logic is_div(input logic [31:0] ins);
      return (ins[31:26] == OP_SPECIAL) &&
             (ins[5:0] == FN_DIV || ins[5:0] == FN_DIVU);
   endfunction

   // Any instruction that touches HI/LO must wait for the unit to go idle.
   function automatic logic uses_hilo(input logic [31:0] ins);
      return is_muldiv(ins) ||
             ((ins[31:26] == OP_SPECIAL) &&
              (ins[5:0] == FN_MFHI || ins[5:0] == FN_MFLO ||
               ins[5:0] == FN_MTHI || ins[5:0] == FN_MTLO));
   endfunction

   // One operand against one producer stage.
   function automatic logic conflict(input logic       use_v,
                                     input logic [1:0] tuse,
                                     input logic [4:0] src,
                                     input logic [4:0] dst,
                                     input logic [1:0] tnew);
      return use_v && (dst != 5'd0) && (src == dst) && (tuse < tnew);
   endfunction

   src_t       srcD;
   logic [4:0] rsD, rtD;
   logic [4:0] dstE, dstM;
   logic [1:0] tnewE, tnewM;
   logic       data_stall;
   logic       md_stall;
   logic       md_start;
   logic [CNT_W-1:0] cnt;

   always_comb begin
      srcD  = src_of(instrD);
      rsD   = instrD[25:21];
      rtD   = instrD[20:16];
      dstE  = dst_of(instrE);
      dstM  = dst_of(instrM);
      tnewE = tnew_e_of(instrE);
      tnewM = tnew_m_of(instrM);
   end

   always_comb begin
      data_stall = conflict(srcD.rs_v, srcD.rs_t, rsD, dstE, tnewE) |
                   conflict(srcD.rs_v, srcD.rs_t, rsD, dstM, tnewM) |
                   conflict(srcD.rt_v, srcD.rt_t, rtD, dstE, tnewE) |
                   conflict(srcD.rt_v, srcD.rt_t, rtD, dstM, tnewM);
   end

   // The start cycle itself counts as busy, so the counter only covers the tail.
   assign md_start = is_muldiv(instrE);
   assign md_busy  = md_start | (cnt != '0);
   assign md_stall = md_busy & uses_hilo(instrD);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (cnt == '0) begin
         if (md_start)
            cnt <= is_div(instrE) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else begin
         // A new start while busy is dropped; D would have been stalled anyway.
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign stall = data_stall | md_stall;
   assign pc_en = ~stall;
   assign d_en  = ~stall;
   assign e_clr = stall;

endmodule
